// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
// Holds the FSM state encoding, forwarding selects and pipe_en/pipe_flush bit positions.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_RSVD       = 2'd3
  } hz_state_e;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam int EN_PC    = 0;
  localparam int EN_IFID  = 1;
  localparam int EN_IDEX  = 2;
  localparam int EN_EXMEM = 3;
  localparam int EN_MEMWB = 4;

  localparam int FL_IFID  = 0;
  localparam int FL_IDEX  = 1;
  localparam int FL_EXMEM = 2;
  localparam int FL_MEMWB = 3;

  localparam logic [4:0] PIPE_HOLD  = 5'b00000;
  localparam logic [4:0] PIPE_STALL = (5'b1 << EN_IDEX) | (5'b1 << EN_EXMEM) | (5'b1 << EN_MEMWB);
  localparam logic [4:0] PIPE_RUN   = PIPE_STALL | (5'b1 << EN_PC) | (5'b1 << EN_IFID);

  localparam logic [3:0] FLUSH_NONE   = 4'b0000;
  localparam logic [3:0] FLUSH_BUBBLE = 4'b1 << FL_IDEX;
  localparam logic [3:0] FLUSH_BRANCH = FLUSH_BUBBLE | (4'b1 << FL_IFID) | (4'b1 << FL_EXMEM);
  localparam logic [3:0] FLUSH_ALL    = FLUSH_BRANCH | (4'b1 << FL_MEMWB);

  // EX/MEM result is younger than MEM/WB, so it wins; $zero is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic       mem_we,
    input logic [4:0] mem_dest,
    input logic       wb_we,
    input logic [4:0] wb_dest,
    input logic [4:0] src
  );
    if (mem_we && (mem_dest != 5'd0) && (mem_dest == src)) return FWD_MEM;
    if (wb_we && (wb_dest != 5'd0) && (wb_dest == src))    return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational operand-forwarding selects for the two EX-stage ALU inputs.
module hazard_fwd_unit
  import mips_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] mem_dest,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_dest,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_sel(mem_reg_write, mem_dest, wb_reg_write, wb_dest, ex_rs);
  assign fwd_b = fwd_sel(mem_reg_write, mem_dest, wb_reg_write, wb_dest, ex_rt);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/forwarding controller for the 5-stage pipeline; Mealy outputs from a registered FSM.
// States: RUN=0 normal flow | LOAD_STALL=1 extra load-use bubbles | MEM_WAIT=2 data memory busy. HAZARD_PERF_EN adds perf counters.
module pipeline_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 64
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dest,
  input  logic [4:0] mem_dest,
  input  logic       mem_reg_write,
  input  logic       mem_pc_src,
  input  logic [4:0] wb_dest,
  input  logic       wb_reg_write,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic [4:0] pipe_en,
  output logic [3:0] pipe_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic [1:0] state,
  output logic       mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_memwait
`endif
);

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [9:0] WDOG_LIMIT   = 10'(MEM_TIMEOUT);

  hz_state_e  r_state;
  logic [2:0] r_stall_cnt;
  logic [9:0] r_wdog;
  logic       r_mem_timeout;

  logic       w_load_use;
  logic       w_mem_stall;
  logic [9:0] w_wdog_inc;
  logic [4:0] w_en;
  logic [3:0] w_flush;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_load_use  = ex_mem_read && (ex_dest != 5'd0) && ((ex_dest == id_rs) || (ex_dest == id_rt));
  assign w_mem_stall = dmem_req && !dmem_ready;
  assign w_wdog_inc  = (r_wdog == 10'h3FF) ? r_wdog : r_wdog + 10'd1;

  hazard_fwd_unit u_fwd (
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .mem_dest      (mem_dest),
    .mem_reg_write (mem_reg_write),
    .wb_dest       (wb_dest),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (w_fwd_a),
    .fwd_b         (w_fwd_b)
  );

  always_comb begin
    w_en    = PIPE_RUN;
    w_flush = FLUSH_NONE;
    case (r_state)
      ST_MEM_WAIT: begin
        w_en = dmem_ready ? PIPE_RUN : PIPE_HOLD;
      end
      default: begin
        if (w_mem_stall) begin
          w_en = PIPE_HOLD;
        end else if (mem_pc_src) begin
          w_flush = FLUSH_BRANCH;
        end else if ((r_state == ST_LOAD_STALL) || w_load_use) begin
          w_en    = PIPE_STALL;
          w_flush = FLUSH_BUBBLE;
        end
      end
    endcase
  end

  // Reset drives the pipeline into a fully flushed, frozen condition without waiting for a clock.
  assign pipe_en     = RST_N ? w_en    : PIPE_HOLD;
  assign pipe_flush  = RST_N ? w_flush : FLUSH_ALL;
  assign fwd_a       = RST_N ? w_fwd_a : FWD_NONE;
  assign fwd_b       = RST_N ? w_fwd_b : FWD_NONE;
  assign state       = r_state;
  assign mem_timeout = r_mem_timeout;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= ST_RUN;
      r_stall_cnt   <= 3'd0;
      r_wdog        <= 10'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            r_state <= ST_RUN;
            r_wdog  <= 10'd0;
          end else begin
            r_wdog <= w_wdog_inc;
            if (w_wdog_inc == WDOG_LIMIT) r_mem_timeout <= 1'b1;
          end
        end
        default: begin
          if (w_mem_stall) begin
            r_state     <= ST_MEM_WAIT;
            r_wdog      <= 10'd1;
            r_stall_cnt <= 3'd0;
          end else if (mem_pc_src) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= 3'd0;
          end else if (r_state == ST_LOAD_STALL) begin
            if (r_stall_cnt <= 3'd1) begin
              r_state     <= ST_RUN;
              r_stall_cnt <= 3'd0;
            end else begin
              r_stall_cnt <= r_stall_cnt - 3'd1;
            end
          end else if (w_load_use && (LOAD_STALL_CYCLES > 1)) begin
            r_state     <= ST_LOAD_STALL;
            r_stall_cnt <= STALL_RELOAD;
          end else begin
            r_state <= ST_RUN;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_stall   <= 32'd0;
      perf_flush   <= 32'd0;
      perf_memwait <= 32'd0;
    end else begin
      if ((w_flush == FLUSH_BUBBLE) && (perf_stall != 32'hFFFF_FFFF))  perf_stall   <= perf_stall + 32'd1;
      if ((w_flush == FLUSH_BRANCH) && (perf_flush != 32'hFFFF_FFFF))  perf_flush   <= perf_flush + 32'd1;
      if ((w_en == PIPE_HOLD) && (perf_memwait != 32'hFFFF_FFFF))      perf_memwait <= perf_memwait + 32'd1;
    end
  end
`endif

endmodule
